// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier producing the full 2*WIDTH-bit product of
//   DATA1 * DATA2, retiring one partial product per clock.
//
//   A START accepted on edge N raises DONE from edge N+WIDTH to N+WIDTH+1.
//   With START held high, one result is produced every WIDTH+1 cycles.
//
//   Ports
//     CLK        in   1      clock, rising edge
//     RESET      in   1      asynchronous reset, active low
//     START      in   1      request, sampled when BUSY=0 (IDLE or FIN)
//     DATA1      in   WIDTH  multiplicand, captured on accepted START
//     DATA2      in   WIDTH  multiplier, captured on accepted START
//     BUSY       out  1      high while RUN is in progress
//     DONE       out  1      one-cycle pulse when a new product is valid
//     RESULT     out  WIDTH  low half of the product
//     RESULT_HI  out  WIDTH  high half of the product
//
//   Configuration macro: SEQ_MUL_SIGNED_EN
//     When defined, the operands are two's complement and the product is
//     signed. When not defined, operation is unsigned.
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI
);

`ifdef SEQ_MUL_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;        // {partial high half, remaining multiplier bits}
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;

    logic               w_last;
    logic [WIDTH:0]     w_hi_ext;
    logic [WIDTH:0]     w_mc_ext;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    // One add/subtract-and-shift step on the accumulator.
    always_comb begin
        w_last   = (r_cnt == CNT_LAST);
        // The extra top bit keeps the carry (unsigned) or the sign (signed).
        w_hi_ext = {SIGNED_MODE & r_acc[2*WIDTH-1], r_acc[2*WIDTH-1:WIDTH]};
        w_mc_ext = {SIGNED_MODE & r_mcand[WIDTH-1], r_mcand};
        if (r_acc[0]) begin
            // In signed mode the multiplier MSB carries negative weight.
            if (SIGNED_MODE && w_last) begin
                w_sum = w_hi_ext - w_mc_ext;
            end else begin
                w_sum = w_hi_ext + w_mc_ext;
            end
        end else begin
            w_sum = w_hi_ext;
        end
        w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_mcand <= DATA1;
                        r_acc   <= {{WIDTH{1'b0}}, DATA2};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Load outputs with the product including this final step.
                        r_result    <= w_acc_next[WIDTH-1:0];
                        r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_FIN;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign RESULT    = r_result;
    assign RESULT_HI = r_result_hi;

endmodule
